memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 130 +++++++++++++
 tb/tb_memory_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Byte-serial RAM responder for a simple CPU memory port.
// Each request moves one byte per clock at address+i, little-endian. Bytes
// beyond ram_size read as zero and discard writes.
module memory_responder #(
  parameter int unsigned ram_size = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] memory_address,
  output logic [31:0] memory_data_in,
  input  logic [31:0] memory_data_out,
  input  logic [1:0]  memory_data_size,
  input  logic        memory_enable,
  input  logic        memory_operation,
  output logic        memory_ready
);

  localparam int unsigned addr_w = (ram_size > 1) ? $clog2(ram_size) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        op_q;
  logic [31:0] wdata_q;
  logic [1:0]  idx;
  logic        dropped;

  logic [7:0]  mem [ram_size];

  logic [31:0]       byte_addr;
  logic              in_range;
  logic [addr_w-1:0] ram_index;
  logic [7:0]        rd_byte;
  logic [7:0]        wr_byte;
  logic [1:0]        last_idx;

  // Current byte address, range check and per-byte data selection
  always_comb begin
    byte_addr = addr_q + {30'd0, idx};
    in_range  = (byte_addr < ram_size);
    ram_index = byte_addr[addr_w-1:0];
    rd_byte   = in_range ? mem[ram_index] : 8'h00;
    wr_byte   = wdata_q[{idx, 3'b000} +: 8];
    case (size_q)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // RAM write port; contents are never touched by reset
  always_ff @(posedge clock) begin
    if (state == ACCESS && op_q && in_range) begin
      mem[ram_index] <= wr_byte;
    end
  end

  // Request handshake and byte sequencing.
  // Invalid size parks in DONE with ready low for one cycle so ready still
  // rises one edge after acceptance. 'dropped' remembers an enable drop so
  // ready lasts exactly one cycle even if enable comes back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      memory_ready   <= 1'b0;
      memory_data_in <= '0;
      idx            <= '0;
      addr_q         <= '0;
      size_q         <= '0;
      op_q           <= 1'b0;
      wdata_q        <= '0;
      dropped        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memory_enable) begin
            addr_q  <= memory_address;
            size_q  <= memory_data_size;
            op_q    <= memory_operation;
            wdata_q <= memory_data_out;
            idx     <= '0;
            dropped <= 1'b0;
            if (memory_data_size == 2'd3) begin
              memory_data_in <= '0;
              state          <= DONE;
            end else begin
              if (!memory_operation) begin
                memory_data_in <= '0;
              end
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!op_q) begin
            memory_data_in[{idx, 3'b000} +: 8] <= rd_byte;
          end
          if (!memory_enable) begin
            dropped <= 1'b1;
          end
          if (idx == last_idx) begin
            memory_ready <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        DONE: begin
          if (!memory_ready) begin
            memory_ready <= 1'b1;
            if (!memory_enable) begin
              dropped <= 1'b1;
            end
          end else if (!memory_enable || dropped) begin
            memory_ready <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: latency, data, boundaries and reset.
module tb_memory_responder;

  localparam int unsigned ram_size = 65536;

  logic        clock;
  logic        reset;
  logic [31:0] memory_address;
  logic [31:0] memory_data_in;
  logic [31:0] memory_data_out;
  logic [1:0]  memory_data_size;
  logic        memory_enable;
  logic        memory_operation;
  logic        memory_ready;

  int passed;
  int total;

  memory_responder #(.ram_size(ram_size)) dut (
    .clock            (clock),
    .reset            (reset),
    .memory_address   (memory_address),
    .memory_data_in   (memory_data_in),
    .memory_data_out  (memory_data_out),
    .memory_data_size (memory_data_size),
    .memory_enable    (memory_enable),
    .memory_operation (memory_operation),
    .memory_ready     (memory_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Full handshake: raise enable, wait for ready (bounded), hold enable
  // 'hold' extra cycles, drop enable and sample ready after the next edge.
  task automatic access(input logic [31:0] a, input logic [1:0] sz, input logic op,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output int lat,
                        output bit held_ok, output bit cleared_ok);
    @(negedge clock);
    memory_address   = a;
    memory_data_size = sz;
    memory_operation = op;
    memory_data_out  = wd;
    memory_enable    = 1'b1;
    @(posedge clock);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (memory_ready === 1'b1) begin
        lat = c;
        break;
      end
    end
    rd = memory_data_in;
    held_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      if (memory_ready !== 1'b1 || memory_data_in !== rd) held_ok = 1'b0;
    end
    @(negedge clock);
    memory_enable = 1'b0;
    @(posedge clock); #1;
    cleared_ok = (memory_ready === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (memory_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", memory_ready);
    else passed++;
    total++;
    if (memory_data_in !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", memory_data_in);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; int lat; bit h, cl;
    access(32'h100, 2'd2, 1'b1, 32'hDEADBEEF, 0, rd, lat, h, cl);
    total++;
    if (lat !== 4) $display("FAIL word_write_lat: got %0d expected 4", lat);
    else passed++;
    access(32'h100, 2'd2, 1'b0, 32'h0, 0, rd, lat, h, cl);
    total++;
    if (lat !== 4) $display("FAIL word_read_lat: got %0d expected 4", lat);
    else passed++;
    total++;
    if (rd !== 32'hDEADBEEF) $display("FAIL word_read_data: got %h expected deadbeef", rd);
    else passed++;
    total++;
    if (cl !== 1'b1) $display("FAIL word_ready_clear: got %b expected 1", cl);
    else passed++;
    access(32'h101, 2'd0, 1'b0, 32'h0, 0, rd, lat, h, cl);
    total++;
    if (lat !== 1) $display("FAIL byte_read_lat: got %0d expected 1", lat);
    else passed++;
    total++;
    if (rd !== 32'h000000BE) $display("FAIL byte_read_data: got %h expected 000000be", rd);
    else passed++;
  endtask

  task automatic test_halfword();
    logic [31:0] rd; int lat; bit h, cl;
    access(32'h102, 2'd1, 1'b0, 32'h0, 0, rd, lat, h, cl);
    total++;
    if (lat !== 2) $display("FAIL half_read_lat: got %0d expected 2", lat);
    else passed++;
    total++;
    if (rd !== 32'h0000DEAD) $display("FAIL half_read_data: got %h expected 0000dead", rd);
    else passed++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; int lat; bit h, cl;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    access(32'h0FFE, 2'd2, 1'b1, 32'h11223344, 0, rd, lat, h, cl);
    total++;
    if (lat !== 4) $display("FAIL misaligned_write_lat: got %0d expected 4", lat);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      access(32'h0FFE + i, 2'd0, 1'b0, 32'h0, 0, rd, lat, h, cl);
      total++;
      if (rd !== {24'h0, exp_b[i]})
        $display("FAIL misaligned_byte%0d: got %h expected %h", i, rd, {24'h0, exp_b[i]});
      else passed++;
    end
  endtask

  task automatic test_top_boundary();
    logic [31:0] rd; int lat; bit h, cl;
    access(32'h0, 2'd2, 1'b1, 32'h0, 0, rd, lat, h, cl);
    access(ram_size - 2, 2'd2, 1'b1, 32'hCAFEBABE, 0, rd, lat, h, cl);
    total++;
    if (lat !== 4) $display("FAIL top_write_lat: got %0d expected 4", lat);
    else passed++;
    access(ram_size - 2, 2'd2, 1'b0, 32'h0, 0, rd, lat, h, cl);
    total++;
    if (rd !== 32'h0000BABE) $display("FAIL top_read_data: got %h expected 0000babe", rd);
    else passed++;
    access(32'h0, 2'd2, 1'b0, 32'h0, 0, rd, lat, h, cl);
    total++;
    if (rd !== 32'h0) $display("FAIL top_no_wrap: got %h expected 00000000", rd);
    else passed++;
  endtask

  task automatic test_size3();
    logic [31:0] rd; int lat; bit h, cl;
    access(32'h100, 2'd2, 1'b0, 32'h0, 0, rd, lat, h, cl);
    access(32'h100, 2'd3, 1'b1, 32'hFFFFFFFF, 5, rd, lat, h, cl);
    total++;
    if (lat !== 1) $display("FAIL size3_lat: got %0d expected 1", lat);
    else passed++;
    total++;
    if (rd !== 32'h0) $display("FAIL size3_data: got %h expected 00000000", rd);
    else passed++;
    total++;
    if (h !== 1'b1) $display("FAIL size3_hold: got %b expected 1", h);
    else passed++;
    total++;
    if (cl !== 1'b1) $display("FAIL size3_clear: got %b expected 1", cl);
    else passed++;
    access(32'h100, 2'd2, 1'b0, 32'h0, 0, rd, lat, h, cl);
    total++;
    if (rd !== 32'hDEADBEEF) $display("FAIL size3_ram_intact: got %h expected deadbeef", rd);
    else passed++;
  endtask

  task automatic test_enable_drop();
    logic [31:0] rd; int lat; bit h, cl;
    int first; int width;
    @(negedge clock);
    memory_address   = 32'h300;
    memory_data_size = 2'd2;
    memory_operation = 1'b1;
    memory_data_out  = 32'h55667788;
    memory_enable    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    memory_enable    = 1'b0;
    memory_address   = 32'h0;
    memory_data_out  = 32'h0;
    first = -1;
    width = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      if (memory_ready === 1'b1) begin
        if (first < 0) first = c;
        width++;
      end
    end
    total++;
    if (first !== 4) $display("FAIL drop_ready_lat: got %0d expected 4", first);
    else passed++;
    total++;
    if (width !== 1) $display("FAIL drop_ready_width: got %0d expected 1", width);
    else passed++;
    total++;
    if (memory_data_in !== 32'hDEADBEEF)
      $display("FAIL write_keeps_data: got %h expected deadbeef", memory_data_in);
    else passed++;
    access(32'h300, 2'd2, 1'b0, 32'h0, 0, rd, lat, h, cl);
    total++;
    if (rd !== 32'h55667788) $display("FAIL drop_write_commit: got %h expected 55667788", rd);
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; int lat; bit h, cl;
    access(32'h200, 2'd2, 1'b1, 32'h12345678, 0, rd, lat, h, cl);
    access(32'h200, 2'd2, 1'b0, 32'h0, 0, rd, lat, h, cl);
    @(negedge clock);
    memory_address   = 32'h200;
    memory_data_size = 2'd2;
    memory_operation = 1'b1;
    memory_data_out  = 32'hAABBCCDD;
    memory_enable    = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    memory_enable = 1'b0;
    #1;
    total++;
    if (memory_ready !== 1'b0) $display("FAIL abort_ready: got %b expected 0", memory_ready);
    else passed++;
    total++;
    if (memory_data_in !== 32'h0) $display("FAIL abort_data: got %h expected 00000000", memory_data_in);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    access(32'h200, 2'd2, 1'b0, 32'h0, 0, rd, lat, h, cl);
    total++;
    if (lat !== 4) $display("FAIL post_reset_lat: got %0d expected 4", lat);
    else passed++;
    total++;
    if (rd !== 32'h1234CCDD) $display("FAIL abort_partial_write: got %h expected 1234ccdd", rd);
    else passed++;
  endtask

  initial begin
    passed           = 0;
    total            = 0;
    reset            = 1'b1;
    memory_address   = '0;
    memory_data_out  = '0;
    memory_data_size = '0;
    memory_enable    = 1'b0;
    memory_operation = 1'b0;
    test_reset();
    test_word_rw();
    test_halfword();
    test_misaligned();
    test_top_boundary();
    test_size3();
    test_enable_drop();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
